// File: rtl/divisor_de_frecuencia_programable.sv
// rtl/divisor_de_frecuencia_programable.sv - multi-channel programmable clock divider
//
// Purpose: each of CANALES channels divides clockBase by its own divisor D
// (clamped to at least 2) and produces a registered square wave plus a
// one-cycle tick per period. A new divisor is written into a per-channel
// shadow register. A running channel applies it at its next wrap, so the
// current period is never cut short. A stopped channel applies it at once.
//
// Ports:
//   clockBase       in   base clock, rising edge
//   reset           in   synchronous active-high reset
//   habilitar       in   per-channel run enable
//   escribir        in   one-cycle divisor write strobe
//   canalEscritura  in   target channel of the write (out-of-range ignored)
//   divisorNuevo    in   divisor value to write
//   clockInt        out  divided clock per channel (registered)
//   pulso           out  one-cycle tick per channel period (registered)
//   pendiente       out  channel holds a divisor not yet applied
module divisor_de_frecuencia_programable #(
  parameter int ANCHO           = 15,
  parameter int CANALES         = 3,
  parameter int DIVISOR_INICIAL = 26667,
  localparam int ANCHO_CANAL    = (CANALES > 1) ? $clog2(CANALES) : 1
) (
  input  logic                   clockBase,
  input  logic                   reset,
  input  logic [CANALES-1:0]     habilitar,
  input  logic                   escribir,
  input  logic [ANCHO_CANAL-1:0] canalEscritura,
  input  logic [ANCHO-1:0]       divisorNuevo,
  output logic [CANALES-1:0]     clockInt,
  output logic [CANALES-1:0]     pulso,
  output logic [CANALES-1:0]     pendiente
);

  // Divisors are stored already clamped, so the counter logic never sees 0 or 1.
  localparam logic [ANCHO-1:0] DIV_RESET =
    (DIVISOR_INICIAL < 2) ? ANCHO'(2) : ANCHO'(DIVISOR_INICIAL);

  function automatic logic [ANCHO-1:0] acotar(input logic [ANCHO-1:0] valor);
    return (valor < ANCHO'(2)) ? ANCHO'(2) : valor;
  endfunction

  for (genvar i = 0; i < CANALES; i++) begin : g_canal
    logic [ANCHO-1:0] cuenta_q, cuenta_d;
    logic [ANCHO-1:0] activo_q, activo_d;
    logic [ANCHO-1:0] sombra_q, sombra_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             pulso_q, pulso_d;
    logic             sel;
    logic             fin;

    // Out-of-range channel numbers match no channel, so such writes are dropped.
    assign sel = escribir && (canalEscritura == ANCHO_CANAL'(i));
    // The active divisor only changes at a wrap or while stopped (count 0),
    // so the count never exceeds D-1 and this is the only wrap point.
    assign fin = (cuenta_q == activo_q - ANCHO'(1));

    always_comb begin
      cuenta_d = cuenta_q;
      activo_d = activo_q;
      sombra_d = sombra_q;
      pend_d   = pend_q;
      clk_d    = 1'b0;
      pulso_d  = 1'b0;

      if (habilitar[i]) begin
        // High for floor(D/2) counts, low for the rest: odd D gets the longer low phase.
        clk_d   = (cuenta_q < (activo_q >> 1));
        pulso_d = fin;
        if (fin) begin
          cuenta_d = '0;
          if (pend_q) begin
            activo_d = sombra_q;
            pend_d   = 1'b0;
          end
        end else begin
          cuenta_d = cuenta_q + ANCHO'(1);
        end
      end else begin
        cuenta_d = '0;
        if (pend_q) begin
          activo_d = sombra_q;
          pend_d   = 1'b0;
        end
      end

      // Applied after the wrap logic: a write landing on a wrap edge stays
      // pending and waits for the following wrap.
      if (sel) begin
        sombra_d = acotar(divisorNuevo);
        pend_d   = 1'b1;
      end
    end

    always_ff @(posedge clockBase) begin
      if (reset) begin
        cuenta_q <= '0;
        activo_q <= DIV_RESET;
        sombra_q <= DIV_RESET;
        pend_q   <= 1'b0;
        clk_q    <= 1'b0;
        pulso_q  <= 1'b0;
      end else begin
        cuenta_q <= cuenta_d;
        activo_q <= activo_d;
        sombra_q <= sombra_d;
        pend_q   <= pend_d;
        clk_q    <= clk_d;
        pulso_q  <= pulso_d;
      end
    end

    assign clockInt[i]  = clk_q;
    assign pulso[i]     = pulso_q;
    assign pendiente[i] = pend_q;
  end

endmodule

// File: tb/tb_divisor_de_frecuencia_programable.sv
// tb/tb_divisor_de_frecuencia_programable.sv - directed bench for the programmable divider
module tb_divisor_de_frecuencia_programable;

  logic        clockBase = 1'b0;
  logic        reset;
  logic [2:0]  habilitar;
  logic        escribir;
  logic [1:0]  canalEscritura;
  logic [14:0] divisorNuevo;
  logic [2:0]  clockInt;
  logic [2:0]  pulso;
  logic [2:0]  pendiente;

  int n_checks = 0;
  int n_fail   = 0;

  divisor_de_frecuencia_programable dut (
    .clockBase      (clockBase),
    .reset          (reset),
    .habilitar      (habilitar),
    .escribir       (escribir),
    .canalEscritura (canalEscritura),
    .divisorNuevo   (divisorNuevo),
    .clockInt       (clockInt),
    .pulso          (pulso),
    .pendiente      (pendiente)
  );

  always #5 clockBase = ~clockBase;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clockBase);
    #1;
  endtask

  task automatic write_div(input logic [1:0] ch, input logic [14:0] val);
    escribir       = 1'b1;
    canalEscritura = ch;
    divisorNuevo   = val;
    tick();
    escribir       = 1'b0;
  endtask

  // First collected sample ends up in the most significant used bit.
  task automatic collect(input int ch, input int n, output logic [31:0] clk_v, output logic [31:0] pul_v);
    clk_v = '0;
    pul_v = '0;
    for (int k = 0; k < n; k++) begin
      tick();
      clk_v = {clk_v[30:0], clockInt[ch]};
      pul_v = {pul_v[30:0], pulso[ch]};
    end
  endtask

  task automatic wait_pulso(input int ch, input int limit, output int miss, output bit ok);
    miss = 0;
    ok   = 1'b0;
    for (int k = 0; k < limit; k++) begin
      tick();
      if (pulso[ch]) begin
        ok = 1'b1;
        break;
      end
      if (!pendiente[ch]) miss++;
    end
  endtask

  initial begin
    logic [31:0] cv, pv;
    int hi, lo, pc, miss;
    bit ok;

    reset = 1'b1; habilitar = 3'b000; escribir = 1'b0;
    canalEscritura = 2'd0; divisorNuevo = 15'd0;
    tick(); tick();
    check_eq("reset_clockInt", {29'd0, clockInt}, 32'd0);
    check_eq("reset_pulso", {29'd0, pulso}, 32'd0);
    check_eq("reset_pendiente", {29'd0, pendiente}, 32'd0);

    // Reset overrides enable and write on the same edge.
    habilitar = 3'b111;
    write_div(2'd1, 15'd4);
    check_eq("reset_wr_pendiente", {29'd0, pendiente}, 32'd0);
    check_eq("reset_en_clockInt", {29'd0, clockInt}, 32'd0);
    reset = 1'b0; habilitar = 3'b000;
    tick();
    check_eq("reset_wr_lost", {29'd0, pendiente}, 32'd0);

    write_div(2'd3, 15'd4);
    check_eq("oob_write_ignored", {29'd0, pendiente}, 32'd0);

    // Default divisor 26667: 13333 high, 13334 low, one tick per period.
    habilitar = 3'b111;
    tick();
    check_eq("first_enabled_high", {29'd0, clockInt}, 32'h7);
    hi = 0; lo = 0; pc = 0;
    while (clockInt[0] && hi < 30000) begin
      hi++;
      if (pulso[0]) pc++;
      tick();
    end
    while (!clockInt[0] && lo < 30000) begin
      lo++;
      if (pulso[0]) pc++;
      tick();
    end
    check_eq("default_high_len", hi, 32'd13333);
    check_eq("default_low_len", lo, 32'd13334);
    check_eq("default_pulses", pc, 32'd1);

    // Divisor 4 on channel 1 written mid-period waits for the wrap.
    write_div(2'd1, 15'd4);
    check_eq("d4_pending_set", {29'd0, pendiente}, 32'h2);
    wait_pulso(1, 30000, miss, ok);
    check_eq("d4_wrap_seen", {31'd0, ok}, 32'd1);
    check_eq("d4_pending_held", miss, 32'd0);
    check_eq("d4_applied", {29'd0, pendiente}, 32'd0);
    check_eq("d4_all_wrap_together", {29'd0, pulso}, 32'h7);
    collect(1, 8, cv, pv);
    check_eq("d4_clk_pattern", cv, 32'hCC);
    check_eq("d4_pulso_pattern", pv, 32'h11);

    // 5 then 0 before the wrap: last wins, clamped to 2.
    write_div(2'd1, 15'd5);
    write_div(2'd1, 15'd0);
    check_eq("d0_pending", {29'd0, pendiente}, 32'h2);
    wait_pulso(1, 10, miss, ok);
    check_eq("d0_wrap_seen", {31'd0, ok}, 32'd1);
    check_eq("d0_applied", {29'd0, pendiente}, 32'd0);
    collect(1, 6, cv, pv);
    check_eq("d2_clk_pattern", cv, 32'h2A);
    check_eq("d2_pulso_pattern", pv, 32'h15);

    // Write on the wrap edge: one more period of D=2, then D=6.
    tick();
    write_div(2'd1, 15'd6);
    check_eq("d6_wrap_edge_pulso", {31'd0, pulso[1]}, 32'd1);
    check_eq("d6_still_pending", {29'd0, pendiente}, 32'h2);
    collect(1, 8, cv, pv);
    check_eq("d6_clk_pattern", cv, 32'hB8);
    check_eq("d6_pulso_pattern", pv, 32'h41);
    check_eq("d6_applied", {29'd0, pendiente}, 32'd0);

    // Disable channel 0 with D=8 pending: applied at once, outputs cleared.
    write_div(2'd0, 15'd8);
    check_eq("d8_pending", {29'd0, pendiente}, 32'h1);
    habilitar = 3'b110;
    tick();
    check_eq("dis_clk0", {31'd0, clockInt[0]}, 32'd0);
    check_eq("dis_pulso0", {31'd0, pulso[0]}, 32'd0);
    check_eq("dis_pending_applied", {29'd0, pendiente}, 32'd0);
    tick(); tick();
    habilitar = 3'b111;
    collect(0, 16, cv, pv);
    check_eq("d8_clk_pattern", cv, 32'hF0F0);
    check_eq("d8_pulso_pattern", pv, 32'h0101);

    // Reset mid-period drops a pending divisor and restarts from the default.
    write_div(2'd2, 15'd4);
    check_eq("ch2_pending", {29'd0, pendiente}, 32'h4);
    reset = 1'b1;
    tick();
    check_eq("midreset_pendiente", {29'd0, pendiente}, 32'd0);
    check_eq("midreset_clockInt", {29'd0, clockInt}, 32'd0);
    check_eq("midreset_pulso", {29'd0, pulso}, 32'd0);
    reset = 1'b0;
    collect(2, 8, cv, pv);
    check_eq("midreset_ch2_default", cv, 32'hFF);
    check_eq("midreset_ch2_no_tick", pv, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divisor_de_frecuencia_programable.md
DIVISOR_DE_FRECUENCIA_PROGRAMABLE -- requirements
Module: divisor_de_frecuencia_programable

Interface
REQ-001 Parameter ANCHO, default 15: width in bits of every counter and divisor.
REQ-002 Parameter CANALES, default 3: number of independent divider channels (min 1).
REQ-003 Parameter DIVISOR_INICIAL, default 26667: divisor loaded into every channel at reset (4 MHz -> 150 Hz).
REQ-004 clockBase  in  1  single base clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 habilitar  in  CANALES  per-channel run enable, bit i controls channel i.
REQ-007 escribir  in  1  one-cycle write strobe for a new divisor.
REQ-008 canalEscritura  in  max(1,$clog2(CANALES))  target channel of the write.
REQ-009 divisorNuevo  in  ANCHO  divisor value written.
REQ-010 clockInt  out  CANALES  divided clock per channel, registered.
REQ-011 pulso  out  CANALES  one-cycle tick per channel period, registered.
REQ-012 pendiente  out  CANALES  high while channel holds an unapplied divisor.

Function
REQ-013 Each channel SHALL hold cuenta (ANCHO bits), divisorActivo, divisorSombra and pendiente.
REQ-014 Effective divisor D SHALL be max(value,2): written or parameter values 0 and 1 are clamped to 2.
REQ-015 Enabled channel: if cuenta == D-1, cuenta SHALL go to 0, else increment by 1; no other wrap.
REQ-016 clockInt[i] SHALL be registered 1 when current cuenta < floor(D/2), else 0 (one-cycle latency from cuenta).
REQ-017 Odd D: high phase floor(D/2) cycles, low phase ceil(D/2) cycles; period always exactly D cycles.
REQ-018 pulso[i] SHALL be registered 1 for exactly one cycle when enabled and cuenta == D-1.
REQ-019 Write with escribir=1 and canalEscritura < CANALES SHALL load divisorSombra and set pendiente of that channel next edge.
REQ-020 Write with canalEscritura >= CANALES SHALL be ignored; no state changes.
REQ-021 Enabled channel with pendiente=1 SHALL copy divisorSombra to divisorActivo and clear pendiente on the edge where cuenta wraps to 0; no mid-period divisor change.
REQ-022 A write in the same cycle as a wrap SHALL NOT be applied at that wrap; it applies at the following wrap.
REQ-023 Repeated writes before application: last value wins; pendiente stays 1.
REQ-024 Disabled channel (habilitar[i]=0): cuenta SHALL clear to 0, clockInt and pulso SHALL be 0 next edge, pending divisor SHALL be applied immediately.
REQ-025 Re-enable SHALL start at cuenta=0, so clockInt rises on the first enabled edge plus one.
REQ-026 Channels SHALL be fully independent; a write to one never disturbs another's count.

Reset
REQ-027 reset=1 at an edge SHALL set every cuenta to 0, divisorActivo and divisorSombra to clamped DIVISOR_INICIAL, pendiente, clockInt, pulso to 0.
REQ-028 reset SHALL override habilitar and escribir in the same cycle; write is lost.
REQ-029 Reset mid-period SHALL discard any pending divisor and restart counting from 0.

Verification
REQ-030 Defaults, reset then habilitar=3'b111 -> each clockInt period 26667 cycles, high 13333, low 13334; pulso once per period.
REQ-031 Write D=4 to channel 1 mid-period -> pendiente[1]=1 until wrap; then clockInt[1] pattern 1,1,0,0 repeating; channels 0,2 unchanged.
REQ-032 Write D=5 then D=0 before wrap -> applied D=2: clockInt toggles every cycle, pulso every 2nd cycle.
REQ-033 Write coinciding with wrap cycle (D=6) -> old divisor for one more full period, then 6-cycle period, high 3.
REQ-034 Drop habilitar[0] mid-count with pending D=8 -> next edge cuenta=0, outputs 0, pendiente[0]=0; re-enable -> 8-cycle period.
REQ-035 Write with canalEscritura=3 (CANALES=3) and reset asserted with escribir -> no state change / reset values only.
